// File: rtl/cpu_control_unit.sv
// -----------------------------------------------------------------------------
// cpu_control_unit
// Multi-cycle controller for the 8-bit core. Holds the PC and the instruction
// register, fetches 16-bit instructions over the imem handshake, decodes them
// into the ALU control word and sequences writeback, data-memory access and
// PC redirection from the ALU result / branch decision.
//
// Ports
//   clk, rst_n            system clock, synchronous active-low reset
//   imem_req/addr         fetch request and address (= pc)
//   imem_valid/rdata      fetch data valid and instruction word
//   rf_raddr_a/b          register read ports (A = operand A, B = operand B
//                         or store data)
//   rf_waddr/we/wsel      register write address, strobe, source select
//                         (0 = alu_result, 1 = dmem_rdata)
//   alu_opcode/dir/
//   alu_is_unsigned/
//   alu_b_sel, imm        ALU control word
//   alu_result,
//   alu_branch_taken      ALU outputs consumed by the controller
//   dmem_req/we/addr      data memory request, store select, address
//   dmem_ack              data access complete
//   pc, halted            current PC, core halted
//
// Opcode map: 0000-0110 R-type (0110 = SHIFT), 0111 LOAD, 1000 STORE,
// 1001 ADDI, 1010 LDI, 1011 BEQ, 1100 BNE, 1101 JMP, 1110 NOP, 1111 HLT.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | imem_req high, wait for imem_valid, load IR, pc += 1
// DECODE  | control word driven from IR; NOP/HLT resolved here
// EXECUTE | latch alu_result; resolve branch/jump
// MEM     | dmem_req high until dmem_ack
// WB      | single-cycle register write strobe
// HALT    | halted; only reset leaves this state
// -----------------------------------------------------------------------------
module cpu_control_unit #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [15:0]     imem_rdata,
    output logic [1:0]      rf_raddr_a,
    output logic [1:0]      rf_raddr_b,
    output logic [1:0]      rf_waddr,
    output logic            rf_we,
    output logic            rf_wsel,
    output logic [3:0]      alu_opcode,
    output logic            alu_dir,
    output logic            alu_is_unsigned,
    output logic            alu_b_sel,
    output logic [7:0]      imm,
    input  logic [7:0]      alu_result,
    input  logic            alu_branch_taken,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [PC_W-1:0] dmem_addr,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    localparam logic [2:0] S_FETCH   = 3'd0;
    localparam logic [2:0] S_DECODE  = 3'd1;
    localparam logic [2:0] S_EXECUTE = 3'd2;
    localparam logic [2:0] S_MEM     = 3'd3;
    localparam logic [2:0] S_WB      = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

    localparam logic [3:0] OP_SHIFT = 4'h6;
    localparam logic [3:0] OP_LOAD  = 4'h7;
    localparam logic [3:0] OP_STORE = 4'h8;
    localparam logic [3:0] OP_LDI   = 4'hA;
    localparam logic [3:0] OP_BEQ   = 4'hB;
    localparam logic [3:0] OP_BNE   = 4'hC;
    localparam logic [3:0] OP_JMP   = 4'hD;
    localparam logic [3:0] OP_NOP   = 4'hE;
    localparam logic [3:0] OP_HLT   = 4'hF;

    logic [2:0]      r_state;
    logic [15:0]     r_ir;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] r_result;

    logic [3:0]      w_op;
    logic            w_rtype;
    logic            w_is_load;
    logic            w_is_store;
    logic            w_is_branch;
    logic [PC_W-1:0] w_imm_sext;

    assign w_op        = r_ir[15:12];
    assign w_rtype     = (w_op <= OP_SHIFT);
    assign w_is_load   = (w_op == OP_LOAD);
    assign w_is_store  = (w_op == OP_STORE);
    assign w_is_branch = (w_op == OP_BEQ) || (w_op == OP_BNE);
    // pc has already been incremented when the branch resolves, so the
    // offset is relative to the instruction after the branch.
    assign w_imm_sext  = PC_W'($signed(r_ir[7:0]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_valid) begin
                        r_ir    <= imem_rdata;
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_op == OP_NOP) begin
                        r_state <= S_FETCH;
                    end else if (w_op == OP_HLT) begin
                        r_state <= S_HALT;
                    end else begin
                        r_state <= S_EXECUTE;
                    end
                end
                S_EXECUTE: begin
                    r_result <= PC_W'(alu_result);
                    if (w_is_branch) begin
                        if (alu_branch_taken) begin
                            r_pc <= r_pc + w_imm_sext;
                        end
                        r_state <= S_FETCH;
                    end else if (w_op == OP_JMP) begin
                        r_pc    <= PC_W'(alu_result);
                        r_state <= S_FETCH;
                    end else if (w_is_load || w_is_store) begin
                        r_state <= S_MEM;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        r_state <= w_is_store ? S_FETCH : S_WB;
                    end
                end
                S_WB:    r_state <= S_FETCH;
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_req        = (r_state == S_FETCH);
    assign imem_addr       = r_pc;
    assign pc              = r_pc;

    // Control word is a pure function of IR, so it stays constant from
    // DECODE until the next fetch completes.
    assign rf_raddr_a      = r_ir[9:8];
    assign rf_raddr_b      = w_rtype ? r_ir[7:6] : r_ir[11:10];
    assign rf_waddr        = r_ir[11:10];
    assign rf_wsel         = w_is_load;
    assign alu_opcode      = w_op;
    assign alu_dir         = (w_op == OP_SHIFT) && r_ir[5];
    assign alu_is_unsigned = w_rtype && r_ir[4];
    assign alu_b_sel       = ((w_op >= OP_LOAD) && (w_op <= OP_LDI)) || (w_op == OP_JMP);
    assign imm             = r_ir[7:0];

    assign rf_we           = (r_state == S_WB);
    assign dmem_req        = (r_state == S_MEM);
    assign dmem_we         = (r_state == S_MEM) && w_is_store;
    assign dmem_addr       = r_result;
    assign halted          = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// -----------------------------------------------------------------------------
// tb_cpu_control_unit
// Drives instructions through the controller while acting as instruction and
// data memory with random wait states. An instruction-level model predicts,
// from the documented latencies and decode rules, the fetch address, control
// word, strobe windows and next PC; a negedge process compares every cycle.
// -----------------------------------------------------------------------------
module tb_cpu_control_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic [1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic        rf_we, rf_wsel;
    logic [3:0]  alu_opcode;
    logic        alu_dir, alu_is_unsigned, alu_b_sel;
    logic [7:0]  imm;
    logic [7:0]  alu_result;
    logic        alu_branch_taken;
    logic        dmem_req, dmem_we;
    logic [7:0]  dmem_addr;
    logic        dmem_ack;
    logic [7:0]  pc;
    logic        halted;

    cpu_control_unit #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_waddr(rf_waddr), .rf_we(rf_we), .rf_wsel(rf_wsel),
        .alu_opcode(alu_opcode), .alu_dir(alu_dir),
        .alu_is_unsigned(alu_is_unsigned), .alu_b_sel(alu_b_sel), .imm(imm),
        .alu_result(alu_result), .alu_branch_taken(alu_branch_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_ack(dmem_ack), .pc(pc), .halted(halted)
    );

    typedef struct packed {
        logic [1:0] ra;
        logic [1:0] rb;
        logic [1:0] wa;
        logic       wsel;
        logic [3:0] op;
        logic       dir;
        logic       uns;
        logic       bsel;
        logic [7:0] imm;
    } cw_t;

    int n_tests = 0;
    int n_fail  = 0;

    // model state for the instruction currently in flight
    logic        chk_en = 1'b0;
    logic [15:0] m_ins  = 16'h0;
    int          m_iw   = 0;
    int          m_dw   = 0;
    int          m_cyc  = 0;
    int          m_T    = 0;
    logic [7:0]  m_pc   = 8'h00;
    logic [7:0]  m_ares = 8'h00;

    function automatic cw_t m_decode(input logic [15:0] ins);
        cw_t c;
        int  op;
        op     = int'(ins[15:12]);
        c.op   = ins[15:12];
        c.ra   = ins[9:8];
        c.wa   = ins[11:10];
        c.imm  = ins[7:0];
        c.rb   = (op <= 6) ? ins[7:6] : ins[11:10];
        c.uns  = (op <= 6) ? ins[4] : 1'b0;
        c.dir  = (op == 6) ? ins[5] : 1'b0;
        c.bsel = ((op >= 7) && (op <= 10)) || (op == 13);
        c.wsel = (op == 7);
        return c;
    endfunction

    function automatic int m_latency(input int op);
        if (op == 7)                         return 5;
        if (op == 11 || op == 12 || op == 13) return 3;
        if (op == 14)                        return 2;
        return 4;
    endfunction

    function automatic bit m_is_mem(input int op);
        return (op == 7) || (op == 8);
    endfunction

    function automatic bit m_writes(input int op);
        return (op <= 7) || (op == 9) || (op == 10);
    endfunction

    function automatic logic [7:0] m_next_pc(input logic [15:0] ins, input logic [7:0] cur,
                                             input logic [7:0] ares, input logic taken);
        int op, t;
        op = int'(ins[15:12]);
        t  = int'(cur) + 1;
        if ((op == 11 || op == 12) && taken) t = t + int'($signed(ins[7:0]));
        if (op == 13) t = int'(ares);
        return 8'(((t % 256) + 256) % 256);
    endfunction

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // per-cycle comparison
    logic [50:0] c_got, c_exp, c_msk;
    cw_t         c_cw;
    int          c_op, c_post;
    logic        c_fetch, c_done, c_mem, c_dwe, c_we, c_halt, c_cwm;
    logic [7:0]  c_pc;

    assign c_got = {imem_req, imem_addr, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel,
                    alu_opcode, alu_dir, alu_is_unsigned, alu_b_sel, imm,
                    dmem_req, dmem_we, dmem_addr, pc, halted};

    always @(negedge clk) begin
        if (chk_en) begin
            c_op    = int'(m_ins[15:12]);
            c_cw    = m_decode(m_ins);
            c_post  = m_cyc - m_iw - 1;
            c_fetch = (m_cyc <= m_iw);
            c_done  = (m_cyc >= m_T);
            c_mem   = !c_done && m_is_mem(c_op) && (c_post >= 2) && (c_post <= 2 + m_dw);
            c_dwe   = c_mem && (c_op == 8);
            c_we    = !c_done && m_writes(c_op) && (c_post == ((c_op == 7) ? 3 + m_dw : 2));
            c_halt  = (c_op == 15) && (c_post >= 1);
            c_cwm   = !c_fetch && !c_done;
            c_pc    = c_fetch ? m_pc : m_pc + 8'd1;
            c_exp = {c_fetch | c_done, m_pc, c_cw.ra, c_cw.rb, c_cw.wa, c_we, c_cw.wsel,
                     c_cw.op, c_cw.dir, c_cw.uns, c_cw.bsel, c_cw.imm,
                     c_mem, c_dwe, m_ares, c_pc, c_halt};
            c_msk = {1'b1, {8{c_fetch}}, {6{c_cwm}}, 1'b1, c_cwm, {7{c_cwm}}, {8{c_cwm}},
                     2'b11, {8{c_mem}}, {8{!c_done}}, 1'b1};
            n_tests++;
            if (((c_got ^ c_exp) & c_msk) != 51'd0) begin
                n_fail++;
                $display("FAIL cycle ins=%h cyc=%0d: got %h, expected %h (mask %h)",
                         m_ins, m_cyc, c_got, c_exp, c_msk);
            end
        end
    end

    // Acts as both memories for one instruction. Returns when the next fetch
    // starts (or after a fixed window for HLT, or at abort_at with reset).
    task automatic run_instr(input logic [15:0] ins, input int iw, input int dw,
                             input logic [7:0] ares, input logic taken, input int abort_at,
                             output int cyc_o, output int we_cnt, output int mem_cnt);
        int op, budget, cyc, dcnt;
        bit fetched;
        op      = int'(ins[15:12]);
        m_ins   = ins;
        m_iw    = iw;
        m_dw    = dw;
        m_ares  = ares;
        m_T     = (op == 15) ? 100000 : m_latency(op) + iw + (m_is_mem(op) ? dw : 0);
        budget  = (op == 15) ? iw + 27 : m_T + 20;
        cyc     = 0;
        dcnt    = 0;
        fetched = 0;
        we_cnt  = 0;
        mem_cnt = 0;
        m_cyc   = 0;
        chk_en  = 1'b1;
        while (1) begin
            if (imem_req && fetched) break;
            if (op == 15 && cyc == budget) break;
            if (cyc > budget) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout ins=%h: no next fetch after %0d cycles", ins, cyc);
                break;
            end
            m_cyc = cyc;
            if (imem_req) begin
                imem_valid = (cyc >= iw);
                imem_rdata = (cyc >= iw) ? ins : 16'($urandom);
                if (cyc >= iw) fetched = 1;
            end else begin
                imem_valid = 1'($urandom);
                imem_rdata = 16'($urandom);
            end
            if (dmem_req) begin
                dmem_ack = (dcnt >= dw);
                dcnt++;
                mem_cnt++;
            end else begin
                dmem_ack = 1'($urandom);
            end
            if (rf_we) we_cnt++;
            if (cyc == iw + 2) begin
                alu_result       = ares;
                alu_branch_taken = taken;
            end else begin
                alu_result       = 8'($urandom);
                alu_branch_taken = 1'($urandom);
            end
            if (cyc == abort_at) begin
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                chk_en = 1'b0;
                cyc_o  = cyc;
                return;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk_en = 1'b0;
        cyc_o  = cyc;
    endtask

    task automatic do_instr(input logic [15:0] ins, input int iw, input int dw,
                            input logic [7:0] ares, input logic taken, output int cyc);
        int op, we_cnt, mem_cnt;
        logic [7:0] nxt;
        op  = int'(ins[15:12]);
        nxt = m_next_pc(ins, m_pc, ares, taken);
        run_instr(ins, iw, dw, ares, taken, -1, cyc, we_cnt, mem_cnt);
        if (op != 15) begin
            check("latency", cyc, m_T);
            check("rf_we_cycles", we_cnt, m_writes(op) ? 1 : 0);
            check("dmem_req_cycles", mem_cnt, m_is_mem(op) ? dw + 1 : 0);
            check("next_pc", int'(imem_addr), int'(nxt));
            m_pc = nxt;
        end else begin
            check("halt_strobes", we_cnt + mem_cnt, 0);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_imem_req"}, int'(imem_req), 1);
        check({tag, "_imem_addr"}, int'(imem_addr), 0);
        check({tag, "_strobes"}, int'({rf_we, dmem_req, dmem_we, halted}), 0);
        check({tag, "_cw"}, int'({alu_opcode, alu_dir, alu_is_unsigned, alu_b_sel, imm, rf_wsel}), 0);
        check({tag, "_dmem_addr"}, int'(dmem_addr), 0);
    endtask

    task automatic do_reset(input string tag);
        chk_en = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        #1;
        check_reset(tag);
        rst_n = 1'b1;
        m_pc  = 8'h00;
    endtask

    task automatic rand_instr();
        logic [15:0] ins;
        int cyc;
        ins = {4'($urandom_range(0, 14)), 12'($urandom)};
        do_instr(ins, $urandom_range(0, 2), $urandom_range(0, 3), 8'($urandom), 1'($urandom), cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, we_cnt, mem_cnt;
        rst_n            = 1'b0;
        imem_valid       = 1'b0;
        imem_rdata       = 16'h0;
        alu_result       = 8'h0;
        alu_branch_taken = 1'b0;
        dmem_ack         = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        m_pc  = 8'h00;

        // model pins
        check("pin_ldi_cw", int'(m_decode(16'hA405)),
              int'({2'd0, 2'd1, 2'd1, 1'b0, 4'hA, 1'b0, 1'b0, 1'b1, 8'h05}));
        check("pin_shift_cw", int'(m_decode(16'h6D30)),
              int'({2'd1, 2'd0, 2'd3, 1'b0, 4'h6, 1'b1, 1'b1, 1'b0, 8'h30}));
        check("pin_beq_pc", int'(m_next_pc(16'hB1FC, 8'h10, 8'h00, 1'b1)), 8'h0D);

        // LDI R1,5 with zero-wait fetch
        do_instr(16'hA405, 0, 0, 8'h05, 1'b0, cyc);
        check("ldi_latency_lit", cyc, 4);
        check("ldi_pc_lit", int'(pc), 8'h01);
        check("ldi_cw_lit", int'({alu_opcode, alu_b_sel, imm, rf_waddr}), int'({4'hA, 1'b1, 8'h05, 2'd1}));

        // STORE R2,[R1+3], ack after 3 wait cycles
        run_instr(16'h8903, 0, 3, 8'h08, 1'b0, -1, cyc, we_cnt, mem_cnt);
        check("store_dmem_cycles_lit", mem_cnt, 4);
        check("store_rf_we_lit", we_cnt, 0);
        check("store_addr_lit", int'(dmem_addr), 8'h08);
        m_pc = m_pc + 8'd1;

        // BEQ at 0x10, taken and not taken
        do_instr(16'hD000, 0, 0, 8'h10, 1'b0, cyc);
        do_instr(16'hB1FC, 0, 0, 8'h00, 1'b1, cyc);
        check("beq_taken_lit", int'(imem_addr), 8'h0D);
        do_instr(16'hD000, 1, 0, 8'h10, 1'b0, cyc);
        do_instr(16'hB1FC, 0, 0, 8'h00, 1'b0, cyc);
        check("beq_not_taken_lit", int'(imem_addr), 8'h11);

        // JMP 0x40, then NOP at 0xFF wraps
        do_instr(16'hD000, 0, 0, 8'h40, 1'b0, cyc);
        check("jmp_lit", int'(imem_addr), 8'h40);
        do_instr(16'hD000, 2, 0, 8'hFF, 1'b0, cyc);
        do_instr(16'hE000, 0, 0, 8'h00, 1'b0, cyc);
        check("nop_wrap_lit", int'(imem_addr), 8'h00);
        check("nop_latency_lit", cyc, 2);

        // SHIFT R3,R1,R0 dir=1 unsigned
        do_instr(16'h6D30, 0, 0, 8'h77, 1'b0, cyc);
        check("shift_cw_lit", int'({alu_opcode, alu_dir, alu_is_unsigned, alu_b_sel, rf_waddr}),
              int'({4'h6, 1'b1, 1'b1, 1'b0, 2'd3}));

        for (int i = 0; i < 150; i++) rand_instr();

        // HLT: halted for the whole observation window
        do_instr(16'hF000, 1, 0, 8'h00, 1'b0, cyc);
        check("halt_lit", int'({halted, imem_req}), 2);

        do_reset("halt_rst");

        // reset during a stalled LOAD memory phase
        run_instr(16'h7123, 0, 10, 8'h55, 1'b0, 5, cyc, we_cnt, mem_cnt);
        check_reset("abort");
        check("abort_rf_we", we_cnt, 0);
        rst_n = 1'b1;
        m_pc  = 8'h00;

        for (int i = 0; i < 10; i++) rand_instr();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
